counter_updown_mod: RTL and testbench



---
 rtl/counter_updown_mod_pkg.sv | 17 +
 rtl/counter_updown_mod_tick_prescaler.sv | 39 +++
 rtl/counter_updown_mod.sv | 95 +++++++++
 tb/tb_counter_updown_mod.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/counter_updown_mod_pkg.sv
// Shared constants and helpers for the modulo-N up/down counter and its prescaler.
package counter_updown_mod_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Smallest r with 2**r >= v; used to size the prescaler register.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/counter_updown_mod_tick_prescaler.sv
// Clock-enable prescaler: emits tick on every PRESCALE-th enabled cycle.
module tick_prescaler
  import counter_updown_mod_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;

  // en=0 freezes the phase so a paused count resumes mid-prescale.
  always_comb begin
    pre_d = pre_q;
    if (clr) begin
      pre_d = '0;
    end else if (en) begin
      pre_d = (pre_q == LAST) ? '0 : pre_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  assign tick = en && (pre_q == LAST);

endmodule

// File: rtl/counter_updown_mod.sv
// Parametrised modulo-N up/down counter with load/clear, wrap or saturate, and event flags.
module counter_updown_mod
  import counter_updown_mod_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MODULUS  = 16,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             evt,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
  localparam bit SAT = (SATURATE == MODE_SAT);

  logic [WIDTH-1:0] count_q, count_d;
  logic             evt_q, evt_d;
  logic             ovf_q, ovf_d;
  logic             step;

  // Load restarts the prescale phase just like clear does.
  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .clr (clr || load),
    .en  (en),
    .tick(step)
  );

  always_comb begin
    count_d = count_q;
    evt_d   = 1'b0;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = (load_val > MAX) ? MAX : load_val;
      if (ovf_clr) ovf_d = 1'b0;
    end else begin
      if (ovf_clr) ovf_d = 1'b0;
      // A boundary step sets ovf after the clear above, so set wins.
      if (step) begin
        if (up) begin
          if (count_q == MAX) begin
            count_d = SAT ? count_q : '0;
            evt_d   = 1'b1;
            ovf_d   = 1'b1;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end else begin
          if (count_q == '0) begin
            count_d = SAT ? count_q : MAX;
            evt_d   = 1'b1;
            ovf_d   = 1'b1;
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      evt_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      evt_q   <= evt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign evt   = evt_q;
  assign ovf   = ovf_q;
  assign tc    = (up && (count_q == MAX)) || (!up && (count_q == '0));

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed bench for counter_updown_mod: wrap, saturate and prescaled instances share one stimulus.
module tb_counter_updown_mod;

  logic       clk;
  logic       rst;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] load_val;
  logic       clr;
  logic       ovf_clr;

  logic [3:0] w_count, s_count, p_count;
  logic       w_tc, s_tc, p_tc;
  logic       w_evt, s_evt, p_evt;
  logic       w_ovf, s_ovf, p_ovf;

  int n_checks;
  int n_errors;
  logic [3:0] exp_q[$];

  counter_updown_mod #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) dut_wrap (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .clr(clr), .ovf_clr(ovf_clr), .count(w_count), .tc(w_tc), .evt(w_evt), .ovf(w_ovf)
  );

  counter_updown_mod #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(1)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .clr(clr), .ovf_clr(ovf_clr), .count(s_count), .tc(s_tc), .evt(s_evt), .ovf(s_ovf)
  );

  counter_updown_mod #(.WIDTH(4), .MODULUS(10), .PRESCALE(3), .SATURATE(0)) dut_pre (
    .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
    .clr(clr), .ovf_clr(ovf_clr), .count(p_count), .tc(p_tc), .evt(p_evt), .ovf(p_ovf)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
    clr = 1'b0; ovf_clr = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] v);
    load = 1'b1; load_val = v;
    tick();
    load = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // 1: wrap up-count through the boundary
    do_reset();
    check("rst_count", w_count, 0);
    check("rst_evt", w_evt, 0);
    check("rst_ovf", w_ovf, 0);
    check("rst_tc_up0", w_tc, 0);
    for (int i = 1; i <= 12; i++) exp_q.push_back(4'(i % 10));
    en = 1'b1; up = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      logic [3:0] e;
      tick();
      e = exp_q.pop_front();
      check($sformatf("up_count_%0d", i), w_count, e);
      check($sformatf("up_evt_%0d", i), w_evt, (i == 10));
      check($sformatf("up_tc_%0d", i), w_tc, (e == 4'd9));
    end
    check("up_ovf_after", w_ovf, 1);

    // 2: down-count wrap, tc at zero, ovf set beats ovf_clr
    en = 1'b0;
    do_load(4'd0);
    check("ld0_count", w_count, 0);
    check("ld0_ovf_kept", w_ovf, 1);
    up = 1'b0;
    #1;
    check("dn_tc_at0", w_tc, 1);
    en = 1'b1;
    tick(); check("dn_count_9", w_count, 9); check("dn_evt_9", w_evt, 1);
    tick(); check("dn_count_8", w_count, 8); check("dn_evt_8", w_evt, 0);
    tick(); check("dn_count_7", w_count, 7); check("dn_tc_7", w_tc, 0);
    en = 1'b0; ovf_clr = 1'b1;
    tick(); check("ovf_clr_alone", w_ovf, 0);
    ovf_clr = 1'b0;
    do_load(4'd0);
    en = 1'b1; ovf_clr = 1'b1;
    tick();
    check("ovf_set_wins_count", w_count, 9);
    check("ovf_set_wins_evt", w_evt, 1);
    check("ovf_set_wins_ovf", w_ovf, 1);
    ovf_clr = 1'b0;

    // 3: clamped load beats step; clr beats load
    up = 1'b1; en = 1'b1; load = 1'b1; load_val = 4'd12;
    tick();
    load = 1'b0; en = 1'b0;
    check("ld_clamp_count", w_count, 9);
    check("ld_clamp_evt", w_evt, 0);
    clr = 1'b1; load = 1'b1; load_val = 4'd5;
    tick();
    clr = 1'b0; load = 1'b0;
    check("clr_count", w_count, 0);
    check("clr_ovf", w_ovf, 0);

    // 4: saturate mode holds at both boundaries
    do_reset();
    do_load(4'd8);
    up = 1'b1; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("sat_up_count_%0d", i), s_count, 9);
      check($sformatf("sat_up_evt_%0d", i), s_evt, (i > 0));
    end
    check("sat_up_ovf", s_ovf, 1);
    en = 1'b0;
    do_load(4'd1);
    up = 1'b0; en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("sat_dn_count_%0d", i), s_count, 0);
      check($sformatf("sat_dn_evt_%0d", i), s_evt, (i > 0));
    end

    // 5: prescale by 3, then pause en mid-prescale
    do_reset();
    en = 1'b1; up = 1'b1;
    exp_q = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2};
    for (int i = 1; i <= 7; i++) begin
      tick();
      check($sformatf("pre_count_%0d", i), p_count, exp_q.pop_front());
    end
    do_reset();
    en = 1'b1;
    tick(); tick(); tick(); tick();
    check("pre_pause_start", p_count, 1);
    en = 1'b0;
    tick(); tick();
    check("pre_paused", p_count, 1);
    en = 1'b1;
    tick(); check("pre_resume_hold", p_count, 1);
    tick(); check("pre_resume_step", p_count, 2);
    check("pre_no_evt", p_evt, 0);

    // 6: reset overrides load and enable mid-count
    do_reset();
    do_load(4'd9);
    en = 1'b1; up = 1'b1;
    tick();
    en = 1'b0;
    do_load(4'd5);
    check("pre_rst_count", w_count, 5);
    check("pre_rst_ovf", w_ovf, 1);
    rst = 1'b1; en = 1'b1; load = 1'b1; load_val = 4'd7;
    tick();
    rst = 1'b0; load = 1'b0;
    check("rst_mid_count", w_count, 0);
    check("rst_mid_evt", w_evt, 0);
    check("rst_mid_ovf", w_ovf, 0);
    tick(); check("rst_resume_1", w_count, 1);
    tick(); check("rst_resume_2", w_count, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
